// File: rtl/tpum_xbox_seq.sv
// Row sequencer: per row, fetch A and B from XBOX, fire the engine, write C back.
// Optional `define TPUM_SEQ_ABORT_EN adds an abort input that ends a job early with err.
module tpum_xbox_seq #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [ADDR_W-1:0] num_rows,
`ifdef TPUM_SEQ_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              xbox_rd,
  output logic              xbox_wr,
  output logic [ADDR_W-1:0] xbox_addr,
  output logic [DATA_W-1:0] xbox_wdata,
  input  logic [DATA_W-1:0] xbox_rdata,
  output logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] r2_data,
  output logic              eng_start,
  output logic [2:0]        eng_op,
  input  logic              eng_done,
  input  logic [DATA_W-1:0] eng_result
);

  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD_A, S_WAIT_A, S_RD_B, S_WAIT_B, S_EXEC, S_WAIT_ENG, S_WR_C, S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [ADDR_W-1:0]   r_base_a;
  logic [ADDR_W-1:0]   r_base_b;
  logic [ADDR_W-1:0]   r_base_c;
  logic [ADDR_W-1:0]   r_rows;
  logic [ADDR_W-1:0]   r_row;
  logic [LAT_W-1:0]    r_lat;
  logic                r_err;
  logic [DATA_W-1:0]   r_result;

  logic w_op_ok;
  logic w_lat_last;
  logic w_last_row;
  logic w_abort;

  assign w_op_ok    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100);
  assign w_lat_last = (r_lat == LAT_W'(RD_LAT - 1));
  assign w_last_row = (r_row == (r_rows - ADDR_W'(1)));
  assign eng_op     = r_op;

`ifdef TPUM_SEQ_ABORT_EN
  assign w_abort = abort && (r_state != S_IDLE) && (r_state != S_DONE);
`else
  assign w_abort = 1'b0;
`endif

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = (w_op_ok && (num_rows != '0)) ? S_RD_A : S_DONE;
      S_RD_A:     w_next = S_WAIT_A;
      S_WAIT_A:   if (w_lat_last) w_next = S_RD_B;
      S_RD_B:     w_next = S_WAIT_B;
      S_WAIT_B:   if (w_lat_last) w_next = S_EXEC;
      S_EXEC:     w_next = S_WAIT_ENG;
      S_WAIT_ENG: if (eng_done) w_next = S_WR_C;
      S_WR_C:     w_next = w_last_row ? S_DONE : S_RD_A;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_DONE;
  end

  // Bus outputs are decoded from state alone, so address and data are zero whenever no strobe is active.
  always_comb begin
    busy       = (r_state != S_IDLE) && (r_state != S_DONE);
    done       = (r_state == S_DONE);
    err        = (r_state == S_DONE) && r_err;
    xbox_rd    = (r_state == S_RD_A) || (r_state == S_RD_B);
    xbox_wr    = (r_state == S_WR_C);
    eng_start  = (r_state == S_EXEC);
    xbox_addr  = '0;
    xbox_wdata = '0;
    case (r_state)
      S_RD_A: xbox_addr = r_base_a + r_row;
      S_RD_B: xbox_addr = r_base_b + r_row;
      S_WR_C: begin
        xbox_addr  = r_base_c + r_row;
        xbox_wdata = r_result;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_base_a <= '0;
      r_base_b <= '0;
      r_base_c <= '0;
      r_rows   <= '0;
      r_row    <= '0;
      r_lat    <= '0;
      r_err    <= 1'b0;
      r_result <= '0;
      r1_data  <= '0;
      r2_data  <= '0;
    end else begin
      r_state <= w_next;
      r_lat   <= ((r_state == S_WAIT_A) || (r_state == S_WAIT_B)) ? r_lat + LAT_W'(1) : '0;
      if ((r_state == S_IDLE) && start) begin
        r_op     <= op;
        r_base_a <= base_a;
        r_base_b <= base_b;
        r_base_c <= base_c;
        r_rows   <= num_rows;
        r_row    <= '0;
        r_err    <= !w_op_ok;
      end
      if ((r_state == S_WAIT_A) && w_lat_last) r1_data <= xbox_rdata;
      if ((r_state == S_WAIT_B) && w_lat_last) r2_data <= xbox_rdata;
      if ((r_state == S_WAIT_ENG) && eng_done) r_result <= eng_result;
      if ((r_state == S_WR_C) && !w_last_row) r_row <= r_row + ADDR_W'(1);
      if (w_abort) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tpum_xbox_seq.sv
// Randomized bench for tpum_xbox_seq: an XBOX/engine responder plus a job-level
// scoreboard derived from the row-processing rules (addresses, latencies, done timing).
module tb_tpum_xbox_seq;

  localparam int DW = 128;
  localparam int AW = 14;
  localparam int RL = 2;
  localparam int M_NORM  = 0;
  localparam int M_MID   = 1;
  localparam int M_RST   = 2;
  localparam int M_ABORT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] base_a, base_b, base_c, num_rows;
`ifdef TPUM_SEQ_ABORT_EN
  logic          abort;
`endif
  logic          busy, done, err, xbox_rd, xbox_wr, eng_start, eng_done;
  logic [AW-1:0] xbox_addr;
  logic [DW-1:0] xbox_wdata, xbox_rdata, r1_data, r2_data, eng_result;
  logic [2:0]    eng_op;

  tpum_xbox_seq #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .num_rows(num_rows),
`ifdef TPUM_SEQ_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .err(err),
    .xbox_rd(xbox_rd), .xbox_wr(xbox_wr), .xbox_addr(xbox_addr),
    .xbox_wdata(xbox_wdata), .xbox_rdata(xbox_rdata),
    .r1_data(r1_data), .r2_data(r2_data),
    .eng_start(eng_start), .eng_op(eng_op), .eng_done(eng_done), .eng_result(eng_result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_rd[$];
  logic [AW-1:0] exp_wr[$];
  logic [DW-1:0] exp_r1[$];
  logic [DW-1:0] exp_r2[$];
  logic [DW-1:0] exp_res[$];
  int            eng_delay = 1;
  bit            spur = 1'b0;
  bit            in_job = 1'b0;
  logic [2:0]    job_op = '0;
  int            last_done_cyc = 0;
  int            eng_due = 0;
  bit            eng_pend = 1'b0;
  logic          hist_v [0:RL];
  logic [AW-1:0] hist_a [0:RL];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Contents of XBOX row a, a fixed hash so expected operands can be recomputed.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++)
      w[i*32 +: 32] = (32'(a) + 32'(i) * 32'h10000 + 32'h77) * 32'h9E3779B1;
    return w;
  endfunction

  task automatic check_zero(input string t);
    check({t, "_busy"},  DW'(busy), '0);
    check({t, "_done"},  DW'(done), '0);
    check({t, "_err"},   DW'(err), '0);
    check({t, "_rd"},    DW'(xbox_rd), '0);
    check({t, "_wr"},    DW'(xbox_wr), '0);
    check({t, "_addr"},  DW'(xbox_addr), '0);
    check({t, "_wdata"}, xbox_wdata, '0);
    check({t, "_r1"},    r1_data, '0);
    check({t, "_r2"},    r2_data, '0);
    check({t, "_estart"}, DW'(eng_start), '0);
    check({t, "_eop"},   DW'(eng_op), '0);
  endtask

  task automatic clear_expect();
    exp_rd.delete(); exp_wr.delete(); exp_r1.delete(); exp_r2.delete(); exp_res.delete();
  endtask

  task automatic monitor();
    if (xbox_rd || xbox_wr) check("rd_wr_excl", DW'(xbox_rd & xbox_wr), '0);
    if (!xbox_rd && !xbox_wr) begin
      check("idle_addr", DW'(xbox_addr), '0);
      check("idle_wdata", xbox_wdata, '0);
    end
    if (xbox_rd) begin
      if (exp_rd.size() == 0) check("rd_unexp", DW'(xbox_rd), '0);
      else check("rd_addr", DW'(xbox_addr), DW'(exp_rd.pop_front()));
    end
    if (xbox_wr) begin
      if (exp_wr.size() == 0 || exp_res.size() == 0) check("wr_unexp", DW'(xbox_wr), '0);
      else begin
        check("wr_addr", DW'(xbox_addr), DW'(exp_wr.pop_front()));
        check("wr_data", xbox_wdata, exp_res.pop_front());
        check("wr_latency", DW'(cyc), DW'(last_done_cyc + 1));
      end
    end
    if (eng_start) begin
      if (exp_r1.size() == 0) check("eng_unexp", DW'(eng_start), '0);
      else begin
        check("eng_r1", r1_data, exp_r1.pop_front());
        check("eng_r2", r2_data, exp_r2.pop_front());
        check("eng_op", DW'(eng_op), DW'(job_op));
      end
    end
    if (in_job) check("busy", DW'(busy), DW'(!done));
    if (err) check("err_wo_done", DW'(!done), '0);
  endtask

  // XBOX returns row data only in the cycle RL after its strobe; engine answers eng_delay cycles after eng_start.
  task automatic respond();
    for (int i = RL; i > 0; i--) begin
      hist_v[i] = hist_v[i-1];
      hist_a[i] = hist_a[i-1];
    end
    hist_v[0] = xbox_rd;
    hist_a[0] = xbox_addr;
    xbox_rdata = hist_v[RL] ? mem_word(hist_a[RL]) : rand_word();
    eng_done   = 1'b0;
    eng_result = rand_word();
    if (eng_start) begin
      eng_pend = 1'b1;
      eng_due  = cyc + eng_delay;
      if (spur) eng_done = 1'b1;
    end else if (eng_pend && cyc == eng_due) begin
      eng_done   = 1'b1;
      eng_result = rand_word();
      exp_res.push_back(eng_result);
      last_done_cyc = cyc;
      eng_pend = 1'b0;
    end
  endtask

  initial begin
    xbox_rdata = '0;
    eng_done   = 1'b0;
    eng_result = '0;
    for (int i = 0; i <= RL; i++) begin
      hist_v[i] = 1'b0;
      hist_a[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int i = 0; i <= RL; i++) hist_v[i] = 1'b0;
        eng_pend = 1'b0;
        eng_done = 1'b0;
      end else begin
        monitor();
        respond();
      end
    end
  end

  task automatic run_job(input logic [2:0] j_op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [AW-1:0] c, input logic [AW-1:0] n, input int delay,
                         input bit j_spur, input int mode);
    bit legal, active, seen;
    int rowc, s, exp_done, done_cyc, limit, abort_cyc, nrd, nwr;
    logic [AW-1:0] la;
    legal  = ($countones(j_op) == 1);
    active = legal && (n != '0);
    rowc   = 2 * (1 + RL) + 2 + delay;
    nrd    = active ? int'(n) : 0;
    nwr    = nrd;
    if (mode == M_ABORT) begin
      nrd = 2;
      nwr = 1;
    end
    clear_expect();
    eng_delay = delay;
    spur      = j_spur;
    job_op    = j_op;
    for (int r = 0; r < nrd; r++) begin
      exp_rd.push_back(a + AW'(r));
      exp_rd.push_back(b + AW'(r));
      exp_r1.push_back(mem_word(a + AW'(r)));
      exp_r2.push_back(mem_word(b + AW'(r)));
      if (r < nwr) exp_wr.push_back(c + AW'(r));
    end
    @(negedge clk);
    start = 1'b1; op = j_op; base_a = a; base_b = b; base_c = c; num_rows = n;
    s = cyc;
    abort_cyc = s + 2 + rowc + 2 * (1 + RL);
    if (!active) exp_done = s + 1;
    else if (mode == M_ABORT) exp_done = abort_cyc + 1;
    else exp_done = s + int'(n) * rowc + 1;
    @(negedge clk);
    start = 1'b0;
    op = 3'($urandom); base_a = AW'($urandom); base_b = AW'($urandom);
    base_c = AW'($urandom); num_rows = AW'($urandom_range(1, 3));
    in_job = 1'b1;
    done_cyc = -1;
    limit = int'(n) * rowc + 40;
    for (int k = 0; k < limit; k++) begin
      if (k > 0) @(negedge clk);
      if (mode == M_MID) begin
        start = (cyc == s + 6);
        op = 3'b100;
        num_rows = 2;
      end
`ifdef TPUM_SEQ_ABORT_EN
      abort = (mode == M_ABORT) && (cyc == abort_cyc);
`endif
      if (mode == M_RST && cyc == s + 3 + RL) begin
        #1 rst = 1'b1;
        #1 check_zero("mid_rst");
        clear_expect();
        in_job = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (2 * rowc) begin
          @(negedge clk);
          seen = seen | done | xbox_rd | xbox_wr;
        end
        check("quiet_after_rst", DW'(seen), '0);
        return;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    in_job = 1'b0;
    start  = 1'b0;
`ifdef TPUM_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    if (done_cyc < 0) check("done_seen", DW'(done), DW'(1));
    else begin
      check("done_cycle", DW'(done_cyc - s), DW'(exp_done - s));
      check("err", DW'(err), DW'(!legal || mode == M_ABORT));
    end
    @(negedge clk);
    check("done_pulse", DW'(done), '0);
    check("busy_after", DW'(busy), '0);
    if (mode == M_ABORT) begin
      repeat (delay + 2) @(negedge clk);
      exp_res.delete();
    end
    check("rd_left", DW'(exp_rd.size()), '0);
    check("wr_left", DW'(exp_wr.size()), '0);
    check("eng_left", DW'(exp_r1.size()), '0);
    if (active && mode != M_ABORT) begin
      la = a + n - AW'(1);
      check("r1_hold", r1_data, mem_word(la));
      check("r2_hold", r2_data, mem_word(b + n - AW'(1)));
    end
    spur = 1'b0;
  endtask

  initial begin
    logic [2:0] rop;
    rst = 1'b1; start = 1'b0; op = '0;
    base_a = '0; base_b = '0; base_c = '0; num_rows = '0;
`ifdef TPUM_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_job(3'b001, 14'h010, 14'h020, 14'h030, 14'd1, 1, 1'b0, M_NORM);
    run_job(3'b010, 14'h3FFE, 14'h1234, 14'h2000, 14'd3, 2, 1'b0, M_NORM);
    run_job(3'b011, 14'h100, 14'h200, 14'h300, 14'd2, 1, 1'b0, M_NORM);
    run_job(3'b100, 14'h100, 14'h200, 14'h300, 14'd0, 1, 1'b0, M_NORM);
    run_job(3'b001, 14'h050, 14'h060, 14'h070, 14'd2, 7, 1'b1, M_NORM);
    run_job(3'b010, 14'h111, 14'h222, 14'h333, 14'd2, 1, 1'b0, M_MID);
    run_job(3'b100, 14'h400, 14'h500, 14'h600, 14'd3, 2, 1'b0, M_RST);
    run_job(3'b001, 14'h3FFF, 14'h0AB, 14'h3FFF, 14'd2, 3, 1'b0, M_NORM);
`ifdef TPUM_SEQ_ABORT_EN
    run_job(3'b010, 14'h700, 14'h800, 14'h900, 14'd4, 5, 1'b0, M_ABORT);
`endif
    for (int j = 0; j < 8; j++) begin
      rop = 3'b001 << $urandom_range(0, 2);
      if ($urandom_range(0, 4) == 0) rop = 3'($urandom);
      run_job(rop, AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom_range(0, 4)),
              $urandom_range(1, 4), 1'($urandom_range(0, 1)), M_NORM);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
